// File: rtl/sel_seq_pkg.sv
// Shared types and constants for the select sequencer.
package sel_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sel_state_e;

  localparam logic [1:0] SEL_FIRST = 2'b00;
  localparam logic [1:0] SEL_LAST  = 2'b11;

endpackage

// File: rtl/sel_dwell_cnt.sv
// Dwell counter: counts up from 0 to a latched dwell value, then clears.
// expire is high while the count sits on the latched dwell value.
module sel_dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      dwell_q <= dwell;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      // wrap on the terminal value so the count never exceeds dwell_q
      if (expire) cnt_q <= '0;
      else        cnt_q <= cnt_q + DWELL_W'(1);
    end
  end

  assign expire = (cnt_q == dwell_q);

endmodule

// File: rtl/sel_sequencer.sv
// Steps a 2-bit select code 00->01->10->11, each held for dwell+1 cycles,
// with hold/pause support. Optional wrap-around mode: SEL_SEQUENCER_LOOP_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, select=00
// RUN   | counting dwell, advancing select on each expiry
// PAUSE | hold asserted; select and dwell count frozen
// DONE  | one-cycle completion pulse, select=11, then back to IDLE
module sel_sequencer
  import sel_seq_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SEL_SEQUENCER_LOOP_EN
  input  logic               loop,
`endif
  output logic [1:0]         select,
  output logic               busy,
  output logic               done
);

  sel_state_e state_q, state_nx;
  logic [1:0] sel_q, sel_nx;
  logic       cnt_load, cnt_en, cnt_clr, cnt_expire;

  sel_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .dwell  (dwell),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_FIRST;
    end else begin
      state_q <= state_nx;
      sel_q   <= sel_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    sel_nx   = sel_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_RUN;
          sel_nx   = SEL_FIRST;
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        // hold wins over an expiring step: nothing advances on the pause entry edge
        if (hold) begin
          state_nx = ST_PAUSE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expire) begin
            if (sel_q == SEL_LAST) begin
`ifdef SEL_SEQUENCER_LOOP_EN
              if (loop) sel_nx   = SEL_FIRST;
              else      state_nx = ST_DONE;
`else
              state_nx = ST_DONE;
`endif
            end else begin
              sel_nx = sel_q + 2'd1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (!hold) state_nx = ST_RUN;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        sel_nx   = SEL_FIRST;
        cnt_clr  = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        sel_nx   = SEL_FIRST;
      end
    endcase
  end

  // select is forced low in IDLE so reset takes effect on the output immediately
  assign select = (state_q == ST_IDLE) ? SEL_FIRST : sel_q;
  assign busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done   = (state_q == ST_DONE);

endmodule
